apb_master: RTL and testbench

// - APB requester (bridge side): turns single-beat commands from a local valid/ready port into APB SETUP/ACCESS transfers.
// - Drives psel/penable/paddr/pwrite/pwdata and samples pready/prdata/pslverr from one APB peripheral.
// - Returns a one-cycle response pulse per command. Serves as the initiator end that bus peripherals are verified and integrated against.

---
 rtl/apb_master_if.sv | 30 +++
 rtl/apb_master.sv | 84 ++++++++
 tb/tb_apb_master.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// apb_master_if: local command/response port plus APB requester signals for apb_master.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-beat command port to APB SETUP/ACCESS requester with registered response pulse.
// Optional ACCESS wait timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic        pclk,
  input logic        presetn,
  apb_master_if.master bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  logic [1:0]        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_accept;
  logic              w_done;
  logic              w_tmo;
  assign bus.cmd_ready = (r_state == S_IDLE) && presetn;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign w_done        = (r_state == S_ACCESS) && bus.pready;
`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] r_cnt;
  assign w_tmo = (r_state == S_ACCESS) && !bus.pready && (r_cnt == 16'(TIMEOUT));
  always_ff @(posedge pclk) begin
    if (!presetn) r_cnt <= '0;
    else if (r_state == S_SETUP) r_cnt <= '0;
    else if (r_state == S_ACCESS && !bus.pready) r_cnt <= r_cnt + 16'd1;
  end
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT);
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_state  <= S_SETUP;
        r_psel   <= 1'b1;
        r_paddr  <= bus.cmd_addr;
        r_pwrite <= bus.cmd_write;
        r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
      end else if (r_state == S_SETUP) begin
        r_state   <= S_ACCESS;
        r_penable <= 1'b1;
      end else if (w_done || w_tmo) begin
        r_state     <= S_IDLE;
        r_psel      <= 1'b0;
        r_penable   <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_done ? bus.pslverr : 1'b1;
        // read data only returned for a clean read completion
        r_rsp_rdata <= (w_done && !r_pwrite && !bus.pslverr) ? bus.prdata : '0;
      end
    end
  end
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven transfers with a response scoreboard, plus timeout/hang and mid-transfer reset sequences.
module tb_apb_master;
  localparam int TMO = 4;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int checks = 0;
  int errors = 0;
  rsp_t sbq[$];
  vec_t vtab[6];
  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk),
    .presetn(presetn),
    .bus(bus)
  );
  always #5 pclk = ~pclk;
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    rsp_t e;
    @(negedge pclk);
    chk({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b1;
    bus.prdata    = 32'hBAD0BAD0;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    sbq.push_back(e);
    @(negedge pclk);
    bus.cmd_write = ~v.wr;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    chk({tag, "_setup_ctl"}, 64'({bus.psel, bus.penable, bus.pwrite}), 64'({2'b10, v.wr}));
    chk({tag, "_setup_paddr"}, 64'(bus.paddr), 64'(v.addr));
    chk({tag, "_setup_pwdata"}, 64'(bus.pwdata), 64'(v.wr ? v.wdata : 32'd0));
    for (int c = 0; c <= v.waits; c++) begin
      @(negedge pclk);
      chk({tag, "_access_ctl"}, 64'({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid}), 64'({2'b11, v.wr, 1'b0}));
      chk({tag, "_access_paddr"}, 64'(bus.paddr), 64'(v.addr));
      chk({tag, "_access_pwdata"}, 64'(bus.pwdata), 64'(v.wr ? v.wdata : 32'd0));
      if (c == v.waits) begin
        bus.pready    = 1'b1;
        bus.prdata    = v.prdata;
        bus.pslverr   = v.slverr;
        bus.cmd_valid = 1'b0;
      end
    end
    @(negedge pclk);
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    if (bus.rsp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(e.err));
      chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
    end
    chk({tag, "_idle_bus"}, 64'({bus.psel, bus.penable, bus.cmd_ready}), 64'd1);
    @(negedge pclk);
    chk({tag, "_rsp_pulse"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_hold"}, 64'({bus.rsp_err, bus.rsp_rdata}), 64'({v.exp_err, v.exp_rdata}));
  endtask
  task automatic issue_read(input logic [31:0] addr);
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = addr;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b1;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    int n;
    int bad;
    rsp_t e;
    vtab[0] = '{1'b1, 32'h4,        32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0, 32'h0};
    vtab[1] = '{1'b0, 32'h2,        32'h0,        2, 1'b0, 32'h1234,     1'b0, 32'h1234};
    vtab[2] = '{1'b0, 32'h800,      32'h0,        0, 1'b1, 32'hAAAA,     1'b1, 32'h0};
    vtab[3] = '{1'b1, 32'h10,       32'h55,       1, 1'b1, 32'h77,       1'b1, 32'h0};
    vtab[4] = '{1'b0, 32'hFFFFFFFC, 32'h0,        0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF};
    vtab[5] = '{1'b1, 32'h8,        32'h0,        2, 1'b0, 32'h9999,     1'b0, 32'h0};
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_ctl", 64'({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.cmd_ready}), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    presetn = 1'b1;
    #1;
    chk("rst_release_ready", 64'(bus.cmd_ready), 64'd1);
    for (int i = 0; i < 6; i++) run_vec(vtab[i], $sformatf("v%0d", i));
`ifdef APB_MASTER_TIMEOUT_EN
    issue_read(32'h40);
    e.err = 1'b1;
    e.rdata = 32'h0;
    sbq.push_back(e);
    n = 0;
    while (n < 20 && !bus.rsp_valid) begin
      @(negedge pclk);
      n++;
    end
    chk("tmo_latency", 64'(n), 64'(TMO + 2));
    if (bus.rsp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("tmo_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'({e.err, e.rdata}));
    end
    chk("tmo_idle", 64'({bus.psel, bus.penable, bus.cmd_ready}), 64'd1);
    issue_read(32'h80);
    @(negedge pclk);
`else
    issue_read(32'h40);
    bad = 0;
    repeat (100) begin
      @(negedge pclk);
      if (!(bus.psel && bus.penable) || bus.rsp_valid) bad++;
    end
    chk("hang_access", 64'(bad), 64'd0);
`endif
    chk("mid_access", 64'({bus.psel, bus.penable}), 64'd3);
    presetn = 1'b0;
    @(negedge pclk);
    chk("mid_rst", 64'({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}), 64'd0);
    @(negedge pclk);
    chk("mid_rst_norsp", 64'(bus.rsp_valid), 64'd0);
    presetn = 1'b1;
    run_vec(vtab[1], "post_rst");
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
